// File: rtl/dcm_sp_model.sv
`timescale 1ns/1ps
// Behavioural DCM_SP stand-in: CLK0 pass-through, CLKFX = CLKIN gated by a Bresenham pulse pattern, CLKDV divider, LOCKED.
// Latency: LOCKED on the LOCK_CYCLES-th CLKIN rise after reset release; first CLKFX pulse one cycle after the accumulator first carries.
// Backpressure: none; free-running clock generator, only RST (async, active-low) stops it.
module dcm_sp_model #(
  parameter int CLKFX_MULTIPLY = 4,
  parameter int CLKFX_DIVIDE   = 4,
  parameter int CLKDV_DIVIDE   = 2,
  parameter int LOCK_CYCLES    = 16
) (
  input  logic CLKIN,
  input  logic RST,
  input  logic CLKFB,
  output logic CLK0,
  output logic CLKFX,
  output logic CLKDV,
  output logic LOCKED
);

  // Reject parameter values the rate and divide logic cannot represent.
  if (CLKFX_MULTIPLY < 1 || CLKFX_MULTIPLY > CLKFX_DIVIDE || CLKFX_DIVIDE > 32) begin : g_bad_fx
    $fatal(1, "dcm_sp_model: need 1 <= CLKFX_MULTIPLY <= CLKFX_DIVIDE <= 32");
  end
  if (CLKDV_DIVIDE < 2 || CLKDV_DIVIDE > 16 || (CLKDV_DIVIDE % 2) != 0) begin : g_bad_dv
    $fatal(1, "dcm_sp_model: CLKDV_DIVIDE must be even in 2..16");
  end
  if (LOCK_CYCLES < 1 || LOCK_CYCLES > 255) begin : g_bad_lock
    $fatal(1, "dcm_sp_model: LOCK_CYCLES must be in 1..255");
  end

  // acc < D and M <= D, so acc + M < 2*D always fits without wrapping.
  localparam int              AW         = $clog2(2 * CLKFX_DIVIDE);
  localparam logic [AW-1:0]   M_L        = AW'(CLKFX_MULTIPLY);
  localparam logic [AW-1:0]   D_L        = AW'(CLKFX_DIVIDE);
  localparam logic [7:0]      LOCK_MAX   = 8'(LOCK_CYCLES);
  localparam logic [3:0]      DV_HALF_M1 = 4'(CLKDV_DIVIDE / 2 - 1);

  logic [7:0]    lock_cnt_q, lock_cnt_d;
  logic          locked_q, locked_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] acc_sum;
  logic          pulse_en_q, pulse_en_d;
  logic [3:0]    dv_cnt_q, dv_cnt_d;
  logic          clkdv_q, clkdv_d;
  logic          en_n_q, en_n_d;

  // CLKFB exists only for pin compatibility.
  logic unused_clkfb;
  assign unused_clkfb = CLKFB;

  // Lock counter saturates at LOCK_CYCLES; LOCKED rises on that same edge and sticks.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (lock_cnt_q != LOCK_MAX) begin
      lock_cnt_d = lock_cnt_q + 8'd1;
    end
    if (lock_cnt_d == LOCK_MAX) begin
      locked_d = 1'b1;
    end
  end

  // Phase accumulator: a carry past D means this CLKIN cycle earns a CLKFX pulse.
  always_comb begin
    acc_sum    = acc_q + M_L;
    acc_d      = acc_q;
    pulse_en_d = 1'b0;
    if (locked_q) begin
      if (acc_sum >= D_L) begin
        acc_d      = acc_sum - D_L;
        pulse_en_d = 1'b1;
      end else begin
        acc_d      = acc_sum;
      end
    end
  end

  // CLKDV divider: toggle every CLKDV_DIVIDE/2 locked rising edges, starting low.
  always_comb begin
    dv_cnt_d = dv_cnt_q;
    clkdv_d  = clkdv_q;
    if (locked_q) begin
      if (dv_cnt_q == DV_HALF_M1) begin
        dv_cnt_d = 4'd0;
        clkdv_d  = ~clkdv_q;
      end else begin
        dv_cnt_d = dv_cnt_q + 4'd1;
      end
    end
  end

  // Gate enable is retimed to the falling edge so it only changes while CLKIN is low.
  always_comb begin
    en_n_d = pulse_en_q;
  end

  // Rising-edge state.
  always_ff @(posedge CLKIN or negedge RST) begin
    if (!RST) begin
      lock_cnt_q <= 8'd0;
      locked_q   <= 1'b0;
      acc_q      <= '0;
      pulse_en_q <= 1'b0;
      dv_cnt_q   <= 4'd0;
      clkdv_q    <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      acc_q      <= acc_d;
      pulse_en_q <= pulse_en_d;
      dv_cnt_q   <= dv_cnt_d;
      clkdv_q    <= clkdv_d;
    end
  end

  // Falling-edge gate enable; reset clears it at once so CLKFX drops with no runt.
  always_ff @(negedge CLKIN or negedge RST) begin
    if (!RST) begin
      en_n_q <= 1'b0;
    end else begin
      en_n_q <= en_n_d;
    end
  end

  assign CLK0   = CLKIN;
  assign CLKFX  = CLKIN & en_n_q;
  assign CLKDV  = clkdv_q;
  assign LOCKED = locked_q;

endmodule

// File: tb/tb_dcm_sp_model.sv
`timescale 1ns/1ps
// Bench for dcm_sp_model: three parameterisations share CLKIN/RST.
// Inst 0: M=D=4, CLKDV/2, lock 16. Inst 1: M=25 D=32, CLKDV/4, lock 16. Inst 2: M=1 D=32, CLKDV/16, lock 5.
// A rate-ratio model predicts every half-cycle; literal checks pin lock edge, first pulses and counts.
module tb_dcm_sp_model;

  localparam int PM[3]  = '{4, 25, 1};
  localparam int PD[3]  = '{4, 32, 32};
  localparam int PDV[3] = '{2, 4, 16};
  localparam int PL[3]  = '{16, 16, 5};

  logic       CLKIN = 1'b0;
  logic       RST   = 1'b0;
  logic       CLKFB = 1'b0;
  logic [2:0] c0, fx, dv, lk;

  int errors = 0;
  int checks = 0;
  int e      = 0;
  int cnt[3];
  int hist[3][32];
  int wsum[3];

  dcm_sp_model #(.CLKFX_MULTIPLY(4), .CLKFX_DIVIDE(4), .CLKDV_DIVIDE(2), .LOCK_CYCLES(16)) u0 (
    .CLKIN(CLKIN), .RST(RST), .CLKFB(CLKFB),
    .CLK0(c0[0]), .CLKFX(fx[0]), .CLKDV(dv[0]), .LOCKED(lk[0]));
  dcm_sp_model #(.CLKFX_MULTIPLY(25), .CLKFX_DIVIDE(32), .CLKDV_DIVIDE(4), .LOCK_CYCLES(16)) u1 (
    .CLKIN(CLKIN), .RST(RST), .CLKFB(CLKFB),
    .CLK0(c0[1]), .CLKFX(fx[1]), .CLKDV(dv[1]), .LOCKED(lk[1]));
  dcm_sp_model #(.CLKFX_MULTIPLY(1), .CLKFX_DIVIDE(32), .CLKDV_DIVIDE(16), .LOCK_CYCLES(5)) u2 (
    .CLKIN(CLKIN), .RST(RST), .CLKFB(CLKFB),
    .CLK0(c0[2]), .CLKFX(fx[2]), .CLKDV(dv[2]), .LOCKED(lk[2]));

  always #5 CLKIN = ~CLKIN;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[u%0d] at t=%0t edge=%0d: got %0d expected %0d", nm, inst, $time, e, act, exp);
    end
  endtask

  // Model: after rising edge n (counted from reset release), LOCKED = n >= L.
  function automatic logic exp_lock(input int n, input int l);
    return n >= l;
  endfunction

  // Model: the j-th locked update earns a pulse when floor(j*M/D) steps up;
  // that pulse shows in the CLKIN high phase one edge later.
  function automatic logic exp_fx(input int n, input int m, input int d, input int l);
    int j;
    j = n - 1 - l;
    if (j < 1) return 1'b0;
    return ((j * m) / d) != (((j - 1) * m) / d);
  endfunction

  // Model: after c locked edges CLKDV = floor(c / (DV/2)) mod 2.
  function automatic logic exp_dv(input int n, input int dvd, input int l);
    int c;
    c = n - l;
    if (c < 1) return 1'b0;
    return ((c / (dvd / 2)) % 2) == 1;
  endfunction

  // Per-half-cycle comparison against the model, plus sliding D-window pulse counts.
  always begin
    int ee, w, pos;
    @(posedge CLKIN);
    if (RST) e = e + 1; else e = 0;
    #1;
    ee = RST ? e : 0;
    for (int i = 0; i < 3; i++) begin
      chk("clk0_high", i, 32'(c0[i]), 32'd1);
      chk("locked", i, 32'(lk[i]), 32'(exp_lock(ee, PL[i])));
      chk("clkfx_high", i, 32'(fx[i]), 32'(exp_fx(ee, PM[i], PD[i], PL[i])));
      chk("clkdv", i, 32'(dv[i]), 32'(exp_dv(ee, PDV[i], PL[i])));
      if (ee >= PL[i] + 2) begin
        w   = ee - (PL[i] + 2);
        pos = w % PD[i];
        wsum[i] = wsum[i] + int'(fx[i]) - hist[i][pos];
        hist[i][pos] = int'(fx[i]);
        if (w + 1 >= PD[i]) chk("window_pulses", i, 32'(wsum[i]), 32'(PM[i]));
        if (w < 32000) cnt[i] = cnt[i] + int'(fx[i]);
      end else begin
        wsum[i] = 0;
        for (int k = 0; k < 32; k++) hist[i][k] = 0;
      end
    end
    @(negedge CLKIN);
    #1;
    ee = RST ? e : 0;
    for (int i = 0; i < 3; i++) begin
      chk("clk0_low", i, 32'(c0[i]), 32'd0);
      chk("clkfx_low", i, 32'(fx[i]), 32'd0);
      chk("locked_low", i, 32'(lk[i]), 32'(exp_lock(ee, PL[i])));
      chk("clkdv_low", i, 32'(dv[i]), 32'(exp_dv(ee, PDV[i], PL[i])));
    end
  end

  // The sparse M=1 pulse must be exactly one CLKIN high time (5 ns) wide.
  realtime t_rise = 0.0;
  logic    rise_ok = 1'b0;
  always @(posedge fx[2]) begin
    t_rise  = $realtime;
    rise_ok = RST;
  end
  always @(negedge fx[2]) begin
    if (RST && rise_ok) chk("fx2_width_ps", 2, 32'(int'(($realtime - t_rise) * 1000.0)), 32'd5000);
  end

  // Hand-computed milestones for the first 40 edges after reset release.
  task automatic lock_seq();
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLKIN);
      #2;
      if (k <= 15) chk("lit_lock0_pre", 0, 32'(lk[0]), 32'd0);
      case (k)
        4:  chk("lit_lock2_e4", 2, 32'(lk[2]), 32'd0);
        5:  chk("lit_lock2_e5", 2, 32'(lk[2]), 32'd1);
        12: chk("lit_dv2_e12", 2, 32'(dv[2]), 32'd0);
        13: chk("lit_dv2_e13", 2, 32'(dv[2]), 32'd1);
        16: begin
          chk("lit_lock0_e16", 0, 32'(lk[0]), 32'd1);
          chk("lit_lock1_e16", 1, 32'(lk[1]), 32'd1);
          chk("lit_fx0_e16", 0, 32'(fx[0]), 32'd0);
          chk("lit_dv0_e16", 0, 32'(dv[0]), 32'd0);
        end
        17: begin
          chk("lit_fx0_e17", 0, 32'(fx[0]), 32'd0);
          chk("lit_dv0_e17", 0, 32'(dv[0]), 32'd1);
          chk("lit_dv1_e17", 1, 32'(dv[1]), 32'd0);
        end
        18: begin
          chk("lit_fx0_e18", 0, 32'(fx[0]), 32'd1);
          chk("lit_fx1_e18", 1, 32'(fx[1]), 32'd0);
          chk("lit_dv0_e18", 0, 32'(dv[0]), 32'd0);
          chk("lit_dv1_e18", 1, 32'(dv[1]), 32'd1);
        end
        19: chk("lit_fx1_e19", 1, 32'(fx[1]), 32'd1);
        20: chk("lit_dv1_e20", 1, 32'(dv[1]), 32'd0);
        37: chk("lit_fx2_e37", 2, 32'(fx[2]), 32'd0);
        38: chk("lit_fx2_e38", 2, 32'(fx[2]), 32'd1);
        default: ;
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_locked", i, 32'(lk[i]), 32'd0);
      chk("rst_clkfx", i, 32'(fx[i]), 32'd0);
      chk("rst_clkdv", i, 32'(dv[i]), 32'd0);
    end
    #21;
    RST = 1'b1;

    lock_seq();
    repeat (31990) @(posedge CLKIN);
    #2;
    chk("lit_count_fx0", 0, 32'(cnt[0]), 32'd32000);
    chk("lit_count_fx1", 1, 32'(cnt[1]), 32'd25000);
    chk("lit_count_fx2", 2, 32'(cnt[2]), 32'd1000);

    // Reset in the middle of a CLKFX high phase.
    chk("pre_rst_fx0", 0, 32'(fx[0]), 32'd1);
    RST = 1'b0;
    #1;
    chk("rst_cut_fx0", 0, 32'(fx[0]), 32'd0);
    chk("rst_cut_lock0", 0, 32'(lk[0]), 32'd0);
    chk("rst_cut_clk0", 0, 32'(c0[0]), 32'd1);
    chk("rst_cut_dv1", 1, 32'(dv[1]), 32'd0);
    repeat (3) @(negedge CLKIN);
    #2;
    RST = 1'b1;

    lock_seq();
    repeat (10) @(posedge CLKIN);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcm_sp_model.md
DCM_SP_MODEL -- requirements
Module: dcm_sp_model

Interface
REQ-001 Parameter CLKFX_MULTIPLY, default 4, integer numerator M of the CLKFX rate ratio.
REQ-002 Parameter CLKFX_DIVIDE, default 4, integer denominator D of the CLKFX rate ratio.
REQ-003 Parameter CLKDV_DIVIDE, default 2, even integer divide ratio for CLKDV.
REQ-004 Parameter LOCK_CYCLES, default 16, count of CLKIN rising edges from reset release to LOCKED.
REQ-005 Legal parameter ranges: 1 <= M <= D <= 32; CLKDV_DIVIDE even, 2..16; LOCK_CYCLES 1..255; elaboration SHALL fail on any other value.
REQ-006 CLKIN  input  1  sole clock; all state SHALL change only on CLKIN edges or reset.
REQ-007 RST  input  1  reset; one clock, reset asynchronous and active-low.
REQ-008 CLKFB  input  1  feedback clock, accepted for compatibility, no functional effect.
REQ-009 CLK0  output  1  zero-phase copy of CLKIN.
REQ-010 CLKFX  output  1  gated clock with average rate CLKIN*M/D.
REQ-011 CLKDV  output  1  CLKIN divided by CLKDV_DIVIDE, 50% duty.
REQ-012 LOCKED  output  1  high when outputs are valid.

Function
REQ-013 CLK0 SHALL equal CLKIN combinationally at all times, including during reset.
REQ-014 Lock counter SHALL increment on each CLKIN rising edge after RST release and saturate at LOCK_CYCLES.
REQ-015 LOCKED SHALL go high on the rising edge where the lock counter reaches LOCK_CYCLES, then stay high until reset.
REQ-016 Phase accumulator acc SHALL be ceil(log2(2*D)) bits wide, reset to 0, and update only while LOCKED.
REQ-017 On each rising edge while LOCKED: if acc+M >= D, acc <= acc+M-D and pulse_en <= 1; otherwise acc <= acc+M and pulse_en <= 0.
REQ-018 pulse_en SHALL be 0 whenever LOCKED is 0.
REQ-019 Register en_n SHALL capture pulse_en on the CLKIN falling edge.
REQ-020 CLKFX SHALL equal CLKIN AND en_n, so it is glitch-free and each CLKFX pulse coincides with a CLKIN high phase.
REQ-021 Any D consecutive CLKIN cycles while LOCKED SHALL contain exactly M CLKFX pulses; the pattern is deterministic from reset.
REQ-022 When M = D, CLKFX SHALL equal CLKIN from the first cycle after pulse_en first sets.
REQ-023 CLKDV counter SHALL run only while LOCKED; CLKDV SHALL toggle every CLKDV_DIVIDE/2 rising edges, starting low.
REQ-024 The first CLKFX pulse SHALL appear no earlier than the CLKIN high phase following the first rising edge at which LOCKED is sampled high.
REQ-025 All arithmetic SHALL be unsigned and SHALL never wrap: acc stays < D, and the counters saturate or reload explicitly.

Reset
REQ-026 RST low SHALL immediately force acc=0, pulse_en=0, en_n=0, lock counter=0, CLKDV counter=0, CLKDV=0, LOCKED=0, CLKFX=0.
REQ-027 Asserting RST mid-operation SHALL cut CLKFX low within the same instant with no runt pulse; CLK0 keeps toggling.
REQ-028 After RST rises, behaviour SHALL repeat cycle-for-cycle identically to the sequence following power-up reset.

Verification
REQ-029 Scenario: LOCK_CYCLES=16, release RST -> LOCKED=0 through edge 15, LOCKED=1 on edge 16, CLKFX and CLKDV low until then.
REQ-030 Scenario: M=25, D=32, 32000 CLKIN cycles after lock -> exactly 25000 CLKFX rising edges, and every 32-cycle window holds 25 pulses.
REQ-031 Scenario: M=D=4 -> after lock, CLKFX is bit-identical to CLKIN.
REQ-032 Scenario: CLKDV_DIVIDE=4 -> after lock, CLKDV is high for 2 CLKIN cycles, low for 2, repeating.
REQ-033 Scenario: assert RST while CLKIN is high and CLKFX is high -> CLKFX drops to 0 immediately, LOCKED=0; CLK0 continues to follow CLKIN.
REQ-034 Scenario: M=1, D=32 -> exactly one CLKFX pulse per 32 CLKIN cycles; each pulse's width equals the CLKIN high time.
